// File: rtl/m_imem_loader_if.sv
//------------------------------------------------------------------------------
// Module   : m_imem_loader_if
// Brief    : Byte-stream input and memory-write/status output bundle of the loader.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface m_imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic              w_rx_valid;
    logic [7:0]        w_rx_data;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [31:0]       w_mem_din;
    logic              w_ce_out;
    logic              w_busy;
    logic              w_err;
    logic [ADDR_W:0]   w_nwords;

    modport master (
        output w_rx_valid, w_rx_data,
        input  w_mem_we, w_mem_addr, w_mem_din, w_ce_out, w_busy, w_err, w_nwords
    );

    modport slave (
        input  w_rx_valid, w_rx_data,
        output w_mem_we, w_mem_addr, w_mem_din, w_ce_out, w_busy, w_err, w_nwords
    );
endinterface

`default_nettype wire

// File: rtl/m_imem_loader.sv
//------------------------------------------------------------------------------
// Module   : m_imem_loader
// Brief    : Framed byte-stream image loader for the instruction memory; gates
//            the processor clock-enable until a checksum-valid image is written.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module m_imem_loader #(
    parameter int          ADDR_W = 12,
    parameter int          DEPTH  = 2**ADDR_W,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic            w_clk,
    input  logic            w_rst,
    m_imem_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CNT0 = 3'd1,
        S_CNT1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [16:0]   c_DEPTH   = 17'(DEPTH);
    localparam logic [ADDR_W:0] c_IDX_ONE = (ADDR_W+1)'(1);

    state_t              r_state;
    logic [7:0]          r_cnt_lo;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     r_word_idx;
    logic [1:0]          r_byte_idx;
    logic [7:0]          r_csum;
    logic [23:0]         r_word;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_din;
    logic                r_ce_out;
    logic                r_busy;
    logic                r_err;
    logic [ADDR_W:0]     r_nwords;

    logic [15:0]         w_n;
    logic                w_n_bad;
    logic [7:0]          w_csum_next;
    logic [ADDR_W:0]     w_idx_next;
    logic                w_is_header;

    assign w_n         = {bus.w_rx_data, r_cnt_lo};
    assign w_n_bad     = (w_n == 16'd0) || ({1'b0, w_n} > c_DEPTH);
    assign w_csum_next = r_csum + bus.w_rx_data;
    // Index is one bit wider than the address so a full-depth image can terminate.
    assign w_idx_next  = r_word_idx + c_IDX_ONE;
    assign w_is_header = (bus.w_rx_data == HEADER);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state    <= S_IDLE;
            r_cnt_lo   <= 8'd0;
            r_cnt      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_csum     <= 8'd0;
            r_word     <= 24'd0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= 32'd0;
            r_ce_out   <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_nwords   <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (bus.w_rx_valid) begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (w_is_header) begin
                            r_state    <= S_CNT0;
                            r_csum     <= 8'd0;
                            r_word_idx <= '0;
                            r_byte_idx <= 2'd0;
                            r_ce_out   <= 1'b0;
                            r_err      <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                    S_CNT0: begin
                        r_cnt_lo <= bus.w_rx_data;
                        r_csum   <= w_csum_next;
                        r_state  <= S_CNT1;
                    end
                    S_CNT1: begin
                        r_csum <= w_csum_next;
                        if (w_n_bad) begin
                            r_state  <= S_ERR;
                            r_err    <= 1'b1;
                            r_ce_out <= 1'b0;
                            r_busy   <= 1'b0;
                        end else begin
                            r_cnt   <= w_n[ADDR_W:0];
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_csum     <= w_csum_next;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        // Little-endian: earlier bytes migrate toward the low end.
                        r_word     <= {bus.w_rx_data, r_word[23:8]};
                        if (r_byte_idx == 2'd3) begin
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= r_word_idx[ADDR_W-1:0];
                            r_mem_din  <= {bus.w_rx_data, r_word};
                            r_word_idx <= w_idx_next;
                            if (w_idx_next == r_cnt) begin
                                r_state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        r_busy <= 1'b0;
                        if (bus.w_rx_data == r_csum) begin
                            r_state  <= S_DONE;
                            r_ce_out <= 1'b1;
                            r_err    <= 1'b0;
                            r_nwords <= r_cnt;
                        end else begin
                            r_state  <= S_ERR;
                            r_ce_out <= 1'b0;
                            r_err    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.w_mem_we   = r_mem_we;
    assign bus.w_mem_addr = r_mem_addr;
    assign bus.w_mem_din  = r_mem_din;
    assign bus.w_ce_out   = r_ce_out;
    assign bus.w_busy     = r_busy;
    assign bus.w_err      = r_err;
    assign bus.w_nwords   = r_nwords;

endmodule

`default_nettype wire
